// File: rtl/vdc_pkg.sv
// vdc_pkg: slot encoding and fetch-window constants shared by the VDC slot scheduler.
package vdc_pkg;

   typedef enum bit [2:0] {
      SL_IDLE,
      SL_CHAR,
      SL_RFSH,
      SL_SCRN,
      SL_ATTR,
      SL_CPU
   } slot_t;

   // Screen/attribute fetch window is [SCAC_FIRST, ht - SCAC_TAIL).
   localparam int unsigned SCAC_FIRST = 2;
   localparam int unsigned SCAC_TAIL  = 2;

endpackage

// File: rtl/vdc_starve_ctr.sv
// vdc_starve_ctr: saturating count of slots lost by a pending CPU request.
// starved is raised once CPU_MAX_WAIT slots have been lost since the last clear.
module vdc_starve_ctr #(
   parameter int unsigned CPU_MAX_WAIT = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam int unsigned CntW = (CPU_MAX_WAIT < 2) ? 1 : $clog2(CPU_MAX_WAIT + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(CPU_MAX_WAIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (clr) begin
            cnt_d = '0;
         end else if (inc && (cnt_q < MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starved = (cnt_q >= MaxCnt);

endmodule

// File: rtl/vdc_slot_sched.sv
// vdc_slot_sched: per-column VDC RAM slot arbiter owning screen/attribute indices and refresh row.
// Define VDC_SLOT_STATS_EN to add per-frame CPU/IDLE slot statistics (stat_cpu, stat_idle).
module vdc_slot_sched
   import vdc_pkg::*;
#(
   parameter int unsigned CPU_MAX_WAIT = 8,
   parameter int unsigned IDX_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [7:0]           col,
   input  logic                 newRow,
   input  logic                 row_vis,
   input  logic [7:0]           reg_ht,
   input  logic [7:0]           reg_hd,
   input  logic [3:0]           reg_drr,
   input  logic                 reg_text,
   input  logic                 reg_atr,
   input  logic                 cpu_req,
   output slot_t                slot,
   output logic                 slot_vld,
   output logic                 cpu_grant,
   output logic [IDX_WIDTH-1:0] si,
   output logic [IDX_WIDTH-1:0] ai,
   output logic [7:0]           rfsh_addr
`ifdef VDC_SLOT_STATS_EN
   ,
   output logic [15:0]          stat_cpu,
   output logic [15:0]          stat_idle
`endif
);

   slot_t                slot_q, slot_d, slot_sel;
   logic                 slot_vld_q, slot_vld_d;
   logic                 cpu_grant_q, cpu_grant_d;
   logic [IDX_WIDTH-1:0] si_out_q, si_out_d, ai_out_q, ai_out_d;
   logic [7:0]           rfsh_out_q, rfsh_out_d;
   logic [IDX_WIDTH-1:0] si_q, si_d, ai_q, ai_d, si_cur, ai_cur;
   logic                 si_live_q, si_live_d, ai_live_q, ai_live_d, si_live_cur, ai_live_cur;
   logic [7:0]           rfsh_q, rfsh_d;
   logic                 last_vis_q, last_vis_d;

   logic [8:0] col9, hd9, ht9, rf_end9;
   logic       rf, sa, chr, row_load, scrn_ok, attr_ok, starved, starve_inc, starve_clr;

   always_comb begin
      col9    = {1'b0, col};
      hd9     = {1'b0, reg_hd};
      ht9     = {1'b0, reg_ht};
      rf_end9 = hd9 + {5'b0, reg_drr};
      rf      = (col9 >= hd9) && (col9 < rf_end9);
      // col + tail < ht avoids the underflow of ht - tail for tiny ht
      sa      = !rf && (col9 >= 9'(SCAC_FIRST)) && ((col9 + 9'(SCAC_TAIL)) < ht9);
      chr     = row_vis && (col9 < hd9);
   end

   assign row_load = enable && newRow && (row_vis || last_vis_q);

   always_comb begin
      si_cur      = si_q;
      si_live_cur = si_live_q;
      ai_cur      = ai_q;
      ai_live_cur = ai_live_q;
      if (row_load && !reg_text) begin
         si_cur      = '0;
         si_live_cur = 1'b1;
      end
      if (row_load && reg_atr) begin
         ai_cur      = '0;
         ai_live_cur = 1'b1;
      end
   end

   assign scrn_ok = si_live_cur && (si_cur < IDX_WIDTH'(reg_hd));
   assign attr_ok = ai_live_cur && (ai_cur < IDX_WIDTH'(reg_hd));

   always_comb begin
      if (chr) begin
         slot_sel = SL_CHAR;
      end else if (rf) begin
         slot_sel = SL_RFSH;
      end else if (sa && starved && cpu_req) begin
         slot_sel = SL_CPU;
      end else if (sa && scrn_ok) begin
         slot_sel = SL_SCRN;
      end else if (sa && attr_ok) begin
         slot_sel = SL_ATTR;
      end else if (cpu_req) begin
         slot_sel = SL_CPU;
      end else begin
         slot_sel = SL_IDLE;
      end
   end

   assign starve_inc = cpu_req && !rf && (slot_sel != SL_CPU);
   assign starve_clr = !cpu_req || (slot_sel == SL_CPU);

   vdc_starve_ctr #(
      .CPU_MAX_WAIT(CPU_MAX_WAIT)
   ) u_starve (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (enable),
      .inc    (starve_inc),
      .clr    (starve_clr),
      .starved(starved)
   );

   always_comb begin
      slot_d      = slot_q;
      slot_vld_d  = 1'b0;
      cpu_grant_d = 1'b0;
      si_out_d    = si_out_q;
      ai_out_d    = ai_out_q;
      rfsh_out_d  = rfsh_out_q;
      si_d        = si_q;
      si_live_d   = si_live_q;
      ai_d        = ai_q;
      ai_live_d   = ai_live_q;
      rfsh_d      = rfsh_q;
      last_vis_d  = last_vis_q;
      if (enable) begin
         slot_d      = slot_sel;
         slot_vld_d  = 1'b1;
         cpu_grant_d = (slot_sel == SL_CPU);
         si_out_d    = si_cur;
         ai_out_d    = ai_cur;
         rfsh_out_d  = rfsh_q;
         si_live_d   = si_live_cur;
         ai_live_d   = ai_live_cur;
         si_d        = (slot_sel == SL_SCRN) ? si_cur + 1'b1 : si_cur;
         ai_d        = (slot_sel == SL_ATTR) ? ai_cur + 1'b1 : ai_cur;
         rfsh_d      = (slot_sel == SL_RFSH) ? rfsh_q + 8'd1 : rfsh_q;
         if (newRow) begin
            last_vis_d = row_vis;
         end
      end
   end

`ifdef VDC_SLOT_STATS_EN
   logic [15:0] cnt_cpu_q, cnt_cpu_d, cnt_idle_q, cnt_idle_d;
   logic [15:0] stat_cpu_q, stat_cpu_d, stat_idle_q, stat_idle_d;
   logic        frame_end;

   assign frame_end = enable && newRow && !row_vis && last_vis_q;

   always_comb begin
      cnt_cpu_d   = cnt_cpu_q;
      cnt_idle_d  = cnt_idle_q;
      stat_cpu_d  = stat_cpu_q;
      stat_idle_d = stat_idle_q;
      if (enable) begin
         if (frame_end) begin
            // The slot decided at the frame-end strobe opens the new frame's count
            stat_cpu_d  = cnt_cpu_q;
            stat_idle_d = cnt_idle_q;
            cnt_cpu_d   = {15'd0, slot_sel == SL_CPU};
            cnt_idle_d  = {15'd0, slot_sel == SL_IDLE};
         end else begin
            if ((slot_sel == SL_CPU) && (cnt_cpu_q != 16'hFFFF)) begin
               cnt_cpu_d = cnt_cpu_q + 16'd1;
            end
            if ((slot_sel == SL_IDLE) && (cnt_idle_q != 16'hFFFF)) begin
               cnt_idle_d = cnt_idle_q + 16'd1;
            end
         end
      end
   end

   assign stat_cpu  = stat_cpu_q;
   assign stat_idle = stat_idle_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q      <= SL_IDLE;
         slot_vld_q  <= 1'b0;
         cpu_grant_q <= 1'b0;
         si_out_q    <= '0;
         ai_out_q    <= '0;
         rfsh_out_q  <= '0;
         si_q        <= '0;
         si_live_q   <= 1'b0;
         ai_q        <= '0;
         ai_live_q   <= 1'b0;
         rfsh_q      <= '0;
         last_vis_q  <= 1'b1;
`ifdef VDC_SLOT_STATS_EN
         cnt_cpu_q   <= '0;
         cnt_idle_q  <= '0;
         stat_cpu_q  <= '0;
         stat_idle_q <= '0;
`endif
      end else begin
         slot_q      <= slot_d;
         slot_vld_q  <= slot_vld_d;
         cpu_grant_q <= cpu_grant_d;
         si_out_q    <= si_out_d;
         ai_out_q    <= ai_out_d;
         rfsh_out_q  <= rfsh_out_d;
         si_q        <= si_d;
         si_live_q   <= si_live_d;
         ai_q        <= ai_d;
         ai_live_q   <= ai_live_d;
         rfsh_q      <= rfsh_d;
         last_vis_q  <= last_vis_d;
`ifdef VDC_SLOT_STATS_EN
         cnt_cpu_q   <= cnt_cpu_d;
         cnt_idle_q  <= cnt_idle_d;
         stat_cpu_q  <= stat_cpu_d;
         stat_idle_q <= stat_idle_d;
`endif
      end
   end

   assign slot      = slot_q;
   assign slot_vld  = slot_vld_q;
   assign cpu_grant = cpu_grant_q;
   assign si        = si_out_q;
   assign ai        = ai_out_q;
   assign rfsh_addr = rfsh_out_q;

endmodule

// File: tb/tb_vdc_slot_sched.sv
// tb_vdc_slot_sched: directed and randomized column sequences checked against a
// column-level reference model of the slot rules.
module tb_vdc_slot_sched;
   import vdc_pkg::*;

   localparam int MAXW = 8;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       enable   = 1'b0;
   logic [7:0] col      = 8'd0;
   logic       new_row  = 1'b0;
   logic       row_vis  = 1'b1;
   logic [7:0] reg_ht   = 8'd127;
   logic [7:0] reg_hd   = 8'd80;
   logic [3:0] reg_drr  = 4'd5;
   logic       reg_text = 1'b0;
   logic       reg_atr  = 1'b1;
   logic       cpu_req  = 1'b0;
   slot_t      slot;
   logic       slot_vld, cpu_grant;
   logic [7:0] si, ai, rfsh_addr;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_si, m_ai, m_rfsh, m_starve;
   bit m_si_live, m_ai_live, m_last_vis;

   always #5 clk = ~clk;

   vdc_slot_sched #(
      .CPU_MAX_WAIT(MAXW),
      .IDX_WIDTH   (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .col      (col),
      .newRow   (new_row),
      .row_vis  (row_vis),
      .reg_ht   (reg_ht),
      .reg_hd   (reg_hd),
      .reg_drr  (reg_drr),
      .reg_text (reg_text),
      .reg_atr  (reg_atr),
      .cpu_req  (cpu_req),
      .slot     (slot),
      .slot_vld (slot_vld),
      .cpu_grant(cpu_grant),
      .si       (si),
      .ai       (ai),
      .rfsh_addr(rfsh_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_si = 0; m_ai = 0; m_rfsh = 0; m_starve = 0;
      m_si_live = 1'b0; m_ai_live = 1'b0; m_last_vis = 1'b1;
   endtask

   // One column strobe: predict, clock, compare, then advance the model.
   task automatic strobe(input int c, input bit nr);
      int  hd, ht, drr, e;
      bit  rf, sa, ch, req;
      col = 8'(c); new_row = nr; enable = 1'b1;
      hd = int'(reg_hd); ht = int'(reg_ht); drr = int'(reg_drr); req = cpu_req;
      if (nr) begin
         if (row_vis || m_last_vis) begin
            if (!reg_text) begin m_si = 0; m_si_live = 1'b1; end
            if (reg_atr)   begin m_ai = 0; m_ai_live = 1'b1; end
         end
         m_last_vis = row_vis;
      end
      rf = (c >= hd) && (c < hd + drr);
      sa = !rf && (c >= 2) && (c < ht - 2);
      ch = row_vis && (c < hd);
      if (ch)                          e = SL_CHAR;
      else if (rf)                     e = SL_RFSH;
      else if (sa && m_starve >= MAXW && req) e = SL_CPU;
      else if (sa && m_si_live && m_si < hd)  e = SL_SCRN;
      else if (sa && m_ai_live && m_ai < hd)  e = SL_ATTR;
      else if (req)                    e = SL_CPU;
      else                             e = SL_IDLE;
      @(posedge clk); #1;
      enable = 1'b0; new_row = 1'b0;
      chk("slot", 32'(slot), 32'(e));
      chk("slot_vld", 32'(slot_vld), 32'd1);
      chk("cpu_grant", 32'(cpu_grant), (e == SL_CPU) ? 32'd1 : 32'd0);
      if (e == SL_SCRN) chk("si", 32'(si), 32'(m_si));
      if (e == SL_ATTR) chk("ai", 32'(ai), 32'(m_ai));
      if (e == SL_RFSH) chk("rfsh_addr", 32'(rfsh_addr), 32'(m_rfsh));
      if (e == SL_SCRN) m_si++;
      if (e == SL_ATTR) m_ai++;
      if (e == SL_RFSH) m_rfsh = (m_rfsh + 1) % 256;
      if (!req || e == SL_CPU) m_starve = 0;
      else if (!rf && m_starve < MAXW) m_starve++;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      chk("idle_vld", 32'(slot_vld), 32'd0);
   endtask

   task automatic run_row();
      int n;
      n = (reg_ht == 8'd0) ? 1 : int'(reg_ht);
      for (int c = 0; c < n; c++) strobe(c, c == 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_slot", 32'(slot), 32'(SL_IDLE));
      chk("rst_vld", 32'(slot_vld), 32'd0);
      chk("rst_grant", 32'(cpu_grant), 32'd0);
      chk("rst_si", 32'(si), 32'd0);
      chk("rst_ai", 32'(ai), 32'd0);
      chk("rst_rfsh", 32'(rfsh_addr), 32'd0);
      reset_n = 1'b1;
      idle_cycle();

      // Visible rows: CHAR 0-79, RFSH 80-84 advancing by 5 per line
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 127; c++) begin
            strobe(c, c == 0);
            if (c < 80) chk("t1_char", 32'(slot), 32'(SL_CHAR));
            else if (c < 85) chk("t1_rfsh", 32'(rfsh_addr), 32'(5 * r + c - 80));
         end
      end

      // First invisible row reloads indices; second continues and saturates
      row_vis = 1'b0;
      run_row();
      run_row();

      // Starvation: visible row, then invisible row with cpu_req held
      row_vis = 1'b1;
      run_row();
      row_vis = 1'b0; cpu_req = 1'b1;
      for (int c = 0; c < 127; c++) begin
         strobe(c, c == 0);
         if (c >= 2 && c <= 9) chk("starve_scrn", 32'(slot), 32'(SL_SCRN));
         if (c == 10) begin
            chk("starve_cpu", 32'(slot), 32'(SL_CPU));
            chk("starve_grant", 32'(cpu_grant), 32'd1);
         end
         if (c == 11) chk("starve_clear", 32'(slot), 32'(SL_SCRN));
      end
      cpu_req = 1'b0;

      // Steer refresh row to 254, then check the 254,255,0 wrap
      row_vis = 1'b1; reg_ht = 8'd20; reg_hd = 8'd2;
      while (m_rfsh != 254) begin
         d = (254 - m_rfsh + 256) % 256;
         reg_drr = 4'((d > 15) ? 15 : d);
         run_row();
      end
      reg_drr = 4'd3;
      for (int c = 0; c < 20; c++) begin
         strobe(c, c == 0);
         if (c >= 2 && c <= 4) chk("wrap_addr", 32'(rfsh_addr), 32'((252 + c) % 256));
      end
      strobe(0, 1'b1); strobe(1, 1'b0); strobe(2, 1'b0);
      chk("wrap_next", 32'(rfsh_addr), 32'd1);

      // Reset mid-line while slot_vld is high
      reg_ht = 8'd127; reg_hd = 8'd80; reg_drr = 4'd5;
      for (int c = 0; c < 31; c++) strobe(c, c == 0);
      reset_n = 1'b0;
      #1;
      chk("mrst_slot", 32'(slot), 32'(SL_IDLE));
      chk("mrst_vld", 32'(slot_vld), 32'd0);
      chk("mrst_rfsh", 32'(rfsh_addr), 32'd0);
      chk("mrst_si", 32'(si), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle_cycle();
      idle_cycle();
      run_row();

      // hd=0, drr=0: all CPU with request, all IDLE without
      reg_ht = 8'd20; reg_hd = 8'd0; reg_drr = 4'd0; cpu_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         strobe(c, c == 0);
         chk("hd0_cpu", 32'(slot), 32'(SL_CPU));
      end
      cpu_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         strobe(c, c == 0);
         chk("hd0_idle", 32'(slot), 32'(SL_IDLE));
      end

      // Randomized rows with mid-row register changes and strobe gaps
      for (int r = 0; r < 150; r++) begin
         reg_ht   = 8'($urandom_range(0, 60));
         reg_hd   = 8'($urandom_range(0, int'(reg_ht)));
         reg_drr  = 4'($urandom_range(0, 15));
         row_vis  = 1'($urandom_range(0, 1));
         reg_text = ($urandom_range(0, 3) == 0);
         reg_atr  = ($urandom_range(0, 3) != 0);
         n = (reg_ht == 8'd0) ? 1 : int'(reg_ht);
         for (int c = 0; c < n; c++) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) reg_hd = 8'($urandom_range(0, 60));
            if ($urandom_range(0, 39) == 0) reg_drr = 4'($urandom_range(0, 15));
            strobe(c, c == 0);
            if ($urandom_range(0, 7) == 0) idle_cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
